// File: rtl/softmax_out_collector_pkg.sv
// Shared sizing defaults and state encoding for the softmax result collector.
package softmax_out_collector_pkg;

    localparam int unsigned DEF_DATAWIDTH = 32;
    localparam int unsigned DEF_NUM       = 2;
    localparam int unsigned DEF_ADDRSIZE  = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_COMPLETE = 2'd3
    } state_t;

endpackage

// File: rtl/collect_buffer_ram.sv
// Simple dual-port buffer: one write port, one registered read port with read enable.
module collect_buffer_ram #(
    parameter int unsigned ADDRSIZE = 9,
    parameter int unsigned WIDTH    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDRSIZE-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    input  logic [ADDRSIZE-1:0] rd_addr,
    output logic [WIDTH-1:0]    rd_data
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; storage is never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; output holds whenever rd_en is low and clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/softmax_out_collector.sv
// Captures softmax lane pairs into a window of the buffer, then drains the window in order.
module softmax_out_collector
    import softmax_out_collector_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned NUM       = DEF_NUM,
    parameter int unsigned ADDRSIZE  = DEF_ADDRSIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [ADDRSIZE-1:0]       start_addr,
    input  logic [ADDRSIZE-1:0]       end_addr,
    input  logic [DATAWIDTH-1:0]      outp0,
    input  logic [DATAWIDTH-1:0]      outp1,
    input  logic                      done,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATAWIDTH*NUM-1:0]  m_data,
    output logic [ADDRSIZE-1:0]       m_addr,
    output logic                      m_last,
    output logic                      busy,
    output logic                      complete,
    output logic                      err_overflow,
    output logic                      err_range
);

    localparam int unsigned WORDW = DATAWIDTH * NUM;

    state_t              state;
    logic [ADDRSIZE-1:0] start_q;
    logic [ADDRSIZE-1:0] end_q;
    logic [ADDRSIZE-1:0] wr_ptr;
    logic [ADDRSIZE-1:0] rd_ptr;
    logic [ADDRSIZE-1:0] last_addr;
    logic [WORDW-1:0]    wr_word;
    logic                wr_en;
    logic                rd_en;
    logic                range_bad;

    assign last_addr = end_q - ADDRSIZE'(1);
    assign range_bad = (end_addr <= start_addr);
    assign wr_word   = WORDW'({outp1, outp0});

    // Capture only in COLLECT; a coincident init discards the sample.
    assign wr_en = (state == ST_COLLECT) && done && !init;

    // Prefetch the first word on entering DRAIN, then one word per non-final handshake.
    assign rd_en = (state == ST_DRAIN) && !init
                   && (!m_valid || (m_ready && !m_last));

    // Status decoded straight from the state register.
    assign busy     = (state == ST_COLLECT) || (state == ST_DRAIN);
    assign complete = (state == ST_COMPLETE);

    // The RAM read register doubles as the m_data prefetch register.
    collect_buffer_ram #(
        .ADDRSIZE (ADDRSIZE),
        .WIDTH    (WORDW)
    ) u_buffer (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (m_data)
    );

    // Control FSM with pointers, drain handshake registers and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            start_q      <= '0;
            end_q        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            m_valid      <= 1'b0;
            m_addr       <= '0;
            m_last       <= 1'b0;
            err_overflow <= 1'b0;
            err_range    <= 1'b0;
        end else if (init) begin
            start_q      <= start_addr;
            end_q        <= end_addr;
            wr_ptr       <= start_addr;
            rd_ptr       <= start_addr;
            m_valid      <= 1'b0;
            err_overflow <= 1'b0;
            err_range    <= range_bad;
            state        <= range_bad ? ST_COMPLETE : ST_COLLECT;
        end else begin
            if (done && (state != ST_COLLECT)) begin
                err_overflow <= 1'b1;
            end
            case (state)
                ST_COLLECT: begin
                    if (done) begin
                        wr_ptr <= wr_ptr + ADDRSIZE'(1);
                        if (wr_ptr == last_addr) begin
                            state  <= ST_DRAIN;
                            rd_ptr <= start_q;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready && m_last) begin
                        m_valid <= 1'b0;
                        state   <= ST_COMPLETE;
                    end else if (rd_en) begin
                        m_valid <= 1'b1;
                        m_addr  <= rd_ptr;
                        m_last  <= (rd_ptr == last_addr);
                        rd_ptr  <= rd_ptr + ADDRSIZE'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_out_collector.sv
// Randomized bench for softmax_out_collector against a queue-based window model.
module tb_softmax_out_collector;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init = 1'b0;
    logic          done = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [DW-1:0] outp0 = '0;
    logic [DW-1:0] outp1 = '0;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic          complete;
    logic          err_overflow;
    logic          err_range;
    logic [2*DW-1:0] m_data;
    logic [AW-1:0]   m_addr;

    int total = 0;
    int bad = 0;

    // Model: words expected out of the current window, in address order.
    logic [2*DW-1:0] exp_data_q[$];
    logic [AW-1:0]   exp_addr_q[$];
    logic [AW-1:0]   win_end;
    logic [AW-1:0]   next_addr;
    logic [2*DW-1:0] last_word;

    always #5 clk = ~clk;

    softmax_out_collector #(
        .DATAWIDTH (DW),
        .NUM       (2),
        .ADDRSIZE  (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .outp0        (outp0),
        .outp1        (outp1),
        .done         (done),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_addr       (m_addr),
        .m_last       (m_last),
        .busy         (busy),
        .complete     (complete),
        .err_overflow (err_overflow),
        .err_range    (err_range)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after init is sampled.
    task automatic do_init(input logic [AW-1:0] s, input logic [AW-1:0] e);
        init = 1'b1;
        start_addr = s;
        end_addr = e;
        exp_data_q.delete();
        exp_addr_q.delete();
        win_end = e;
        next_addr = s;
        @(negedge clk);
        init = 1'b0;
    endtask

    // Feeds n random pairs, optionally with random idle gaps between them.
    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            while (gaps && ($urandom_range(0, 2) == 0)) begin
                done = 1'b0;
                @(negedge clk);
            end
            done = 1'b1;
            outp0 = $urandom;
            outp1 = $urandom;
            exp_data_q.push_back({outp1, outp0});
            exp_addr_q.push_back(next_addr);
            next_addr = next_addr + AW'(1);
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    // Drains the window, checking order, last flag and hold-while-stalled.
    task automatic drain(input bit random_ready);
        int              budget = 500;
        bit              held = 1'b0;
        logic [2*DW-1:0] hd;
        logic [AW-1:0]   ha;
        logic [AW-1:0]   ea;
        logic [AW-1:0]   la;
        la = win_end - AW'(1);
        while ((exp_data_q.size() > 0) && (budget > 0)) begin
            m_ready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m_valid) begin
                if (held) begin
                    check("hold_data", m_data, hd);
                    check("hold_addr", 64'(m_addr), 64'(ha));
                end
                if (m_ready) begin
                    ea = exp_addr_q.pop_front();
                    last_word = exp_data_q.pop_front();
                    check("drain_data", m_data, last_word);
                    check("drain_addr", 64'(m_addr), 64'(ea));
                    check("drain_last", 64'(m_last), 64'(ea == la));
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = m_data;
                    ha = m_addr;
                end
            end
            budget--;
            @(negedge clk);
        end
        if (budget == 0) check("drain_timeout", 64'(exp_data_q.size()), 64'd0);
        m_ready = 1'b0;
        check("end_valid", 64'(m_valid), 64'd0);
        check("end_complete", 64'(complete), 64'd1);
        check("end_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_clean_errs(input string tag);
        check({tag, "_ovf"}, 64'(err_overflow), 64'd0);
        check({tag, "_rng"}, 64'(err_range), 64'd0);
    endtask

    initial begin
        int hs;
        int s;
        int len;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", m_data, 64'd0);
        check("rst_addr", 64'(m_addr), 64'd0);
        check("rst_flags", 64'({m_last, busy, complete, err_overflow, err_range}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Stray done while idle.
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("idle_ovf", 64'(err_overflow), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // Directed window 4..8, ready tied high.
        do_init(9'd4, 9'd8);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ovf_clr", 64'(err_overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            done = 1'b1;
            outp1 = 32'((i + 1) * 16 + 1);
            outp0 = 32'((i + 1) * 16);
            @(negedge clk);
        end
        done = 1'b0;
        m_ready = 1'b1;
        check("t1_lat", 64'(m_valid), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", 64'(m_valid), 64'd1);
            check("t1_data", m_data, {32'((i + 1) * 16 + 1), 32'((i + 1) * 16)});
            check("t1_addr", 64'(m_addr), 64'(4 + i));
            check("t1_last", 64'(m_last), 64'(i == 3));
            @(negedge clk);
        end
        check("t1_valid_end", 64'(m_valid), 64'd0);
        check("t1_complete", 64'(complete), 64'd1);
        m_ready = 1'b0;

        // Same window with gappy done and stalled drain.
        do_init(9'd4, 9'd8);
        feed(4, 1'b1);
        drain(1'b1);
        check_clean_errs("t2");

        // Randomized windows.
        for (int k = 0; k < 8; k++) begin
            s = $urandom_range(0, 400);
            len = $urandom_range(1, 12);
            do_init(AW'(s), AW'(s + len));
            feed(len, 1'b1);
            drain(1'b1);
            check_clean_errs("rnd");
        end

        // Empty and inverted windows.
        do_init(9'd10, 9'd10);
        check("rng_complete", 64'(complete), 64'd1);
        check("rng_err", 64'(err_range), 64'd1);
        check("rng_busy", 64'(busy), 64'd0);
        repeat (4) begin
            check("rng_novalid", 64'(m_valid), 64'd0);
            @(negedge clk);
        end
        do_init(9'd30, 9'd20);
        check("inv_err", 64'(err_range), 64'd1);
        check("inv_complete", 64'(complete), 64'd1);

        // done while COMPLETE sets overflow and leaves drained data alone.
        do_init(9'd100, 9'd103);
        check("rng_clr", 64'(err_range), 64'd0);
        feed(3, 1'b0);
        drain(1'b0);
        done = 1'b1;
        outp0 = $urandom;
        outp1 = $urandom;
        @(negedge clk);
        done = 1'b0;
        check("cmp_ovf", 64'(err_overflow), 64'd1);
        check("cmp_hold", 64'(complete), 64'd1);
        check("cmp_data", m_data, last_word);
        check("cmp_valid", 64'(m_valid), 64'd0);
        do_init(9'd100, 9'd103);
        check("cmp_ovf_clr", 64'(err_overflow), 64'd0);
        feed(3, 1'b0);
        drain(1'b1);

        // Reset mid-drain after two handshakes.
        do_init(9'd50, 9'd54);
        feed(4, 1'b0);
        m_ready = 1'b1;
        hs = 0;
        for (int c = 0; (c < 20) && (hs < 2); c++) begin
            if (m_valid) begin
                check("rst_pre_data", m_data, exp_data_q.pop_front());
                void'(exp_addr_q.pop_front());
                hs++;
            end
            @(negedge clk);
        end
        check("rst_pre_hs", 64'(hs), 64'd2);
        check("rst_pre_valid", 64'(m_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_data", m_data, 64'd0);
        check("mid_rst_outs", 64'({m_addr, m_last, busy, complete, err_overflow, err_range}), 64'd0);
        m_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        do_init(9'd50, 9'd54);
        feed(4, 1'b1);
        drain(1'b1);
        check_clean_errs("post_rst");

        // init coincident with done during COLLECT restarts the window.
        do_init(9'd20, 9'd26);
        feed(2, 1'b0);
        init = 1'b1;
        done = 1'b1;
        start_addr = 9'd40;
        end_addr = 9'd43;
        outp0 = 32'hdead_0000;
        outp1 = 32'hdead_0001;
        exp_data_q.delete();
        exp_addr_q.delete();
        win_end = 9'd43;
        next_addr = 9'd40;
        @(negedge clk);
        init = 1'b0;
        done = 1'b0;
        check("coin_busy", 64'(busy), 64'd1);
        feed(3, 1'b1);
        drain(1'b1);
        check_clean_errs("coin");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/softmax_out_collector.md
# softmax_out_collector

Write-side consumer of the softmax engine's result stream. It captures each `{outp1, outp0}` lane pair on every cycle `done` is high and stores it in an internal buffer at consecutive addresses `start_addr .. end_addr-1`, the same address window the engine read its input from. Once the window is full, it drains the buffer in address order over a valid/ready stream to the downstream writeback/DMA path. It sits between `softmax` and the output memory interface.

## Interface
Parameters:
- `DATAWIDTH`, 32, lane width in bits.
- `NUM`, 2, lanes per word; this block is built for `NUM`=2.
- `ADDRSIZE`, 9, buffer address width; depth is `1<<ADDRSIZE`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `init`  in  1  latch the window and arm collection.
- `start_addr`  in  ADDRSIZE  first address of the window.
- `end_addr`  in  ADDRSIZE  exclusive end of the window.
- `outp0`, `outp1`  in  DATAWIDTH each  result lanes from the engine.
- `done`  in  1  per-cycle valid strobe for `outp0`/`outp1`.
- `m_valid`  out  1  drain word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATAWIDTH*NUM  drained word, `{outp1, outp0}`.
- `m_addr`  out  ADDRSIZE  buffer address of `m_data`.
- `m_last`  out  1  high with the final word of the window.
- `busy`  out  1  state is COLLECT or DRAIN.
- `complete`  out  1  high in COMPLETE.
- `err_overflow`  out  1  sticky; set by a `done` that arrives outside COLLECT.
- `err_range`  out  1  sticky; set by `init` with `end_addr <= start_addr`.

## Operation
- States: IDLE, COLLECT, DRAIN, COMPLETE.
- Reset values: state IDLE; all outputs 0. Buffer contents are not cleared.
- `init` in any state:
  - Latches `start_addr` and `end_addr`.
  - Sets `wr_ptr = start_addr` and clears both error flags.
  - Goes to COLLECT.
  - If `end_addr <= start_addr`: goes to COMPLETE instead and sets `err_range`.
  - `init` arriving in COLLECT or DRAIN aborts the current window; any partial data is discarded.
- COLLECT:
  - On each cycle with `done` high: `buffer[wr_ptr] <= {outp1, outp0}` and `wr_ptr` increments. `outp0` occupies bits [DATAWIDTH-1:0].
  - When the captured word is at `end_addr-1`: go to DRAIN with `rd_ptr = start_addr`.
  - Gaps in `done` are allowed and simply stall collection.
- DRAIN:
  - `m_data` and `m_addr` are registers, prefetched from the buffer (synchronous read).
  - Once `m_valid` rises, `m_data`, `m_addr` and `m_last` hold stable until `m_valid && m_ready`.
  - On each handshake, the next word loads in the same edge, so throughput is 1 word/cycle while `m_ready` is high.
  - `m_last` = (`m_addr == end_addr-1`).
  - The handshake on the last word deasserts `m_valid` and goes to COMPLETE.
- COMPLETE: `complete` holds 1 until the next `init`.
- `done` in IDLE, DRAIN or COMPLETE: the sample is dropped and `err_overflow` is set; state is unchanged.
- `init` and `done` in the same cycle: `init` wins and the sample is dropped without setting an error.
- Reset mid-operation: immediate return to IDLE; `m_valid` drops asynchronously.
- Pointers are ADDRSIZE bits. Because `end_addr <= (1<<ADDRSIZE)-1`, no wrap occurs inside a valid window.

## Timing
- Last `done` sampled at edge E:
  - State is DRAIN after E.
  - First word is registered at E+1, so `m_valid` is high in the cycle after E+1 (2 cycles after the last `done` cycle).
- N-word window, `m_ready` tied high: `m_valid` is high for exactly N consecutive cycles. `complete` rises on the edge of the final handshake.
- `init` to COLLECT: 1 edge. The `done` sampled on the edge following that is the first word accepted.
- `busy` and `complete` are decoded directly from the state register and carry no extra latency.

## Structure
- Shared defines/package: `DATAWIDTH`, `NUM`, `ADDRSIZE` (existing defines block) and the state encoding localparams (2-bit).
- Sub-module `collect_buffer_ram`: simple dual-port RAM, depth `1<<ADDRSIZE`, width `DATAWIDTH*NUM`, one write port, one synchronous read port.
- FSM, pointers, prefetch register and error flags live in the top module.

## Test plan
- Window start 4, end 8; `done` for 4 cycles with pairs (0x11,0x10)…(0x41,0x40); `m_ready`=1 → 4 words 0x00000011_00000010 … 0x00000041_00000040, `m_addr` 4..7, `m_last` on addr 7, `complete`=1.
- Same window, `done` toggling every other cycle and `m_ready` low for 3 cycles mid-drain → identical data order; `m_data` stable while stalled; no error flags.
- `init` with start 10, end 10 → COMPLETE next cycle, `err_range`=1, `m_valid` never asserts.
- `done` pulse while in COMPLETE → `err_overflow`=1 and the drained data from the previous window is unchanged. A following `init` clears `err_overflow`.
- Reset asserted (`reset`=0) during DRAIN after 2 of 4 handshakes → `m_valid`=0 immediately, all outputs 0, state IDLE. A new `init` plus 4 words drains correctly.
- `init` coincident with `done` while in COLLECT → window restarts at the new `start_addr`; the coincident sample is not stored.
